// File: rtl/code_entry_selector_if.sv
// Button-pulse and code/cursor bundle between the front end and the selector.
// master drives pulses and reads the code; slave is the selector.
interface code_entry_selector_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DW = 4
);
  localparam int CW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  logic                     enable_entry;
  logic                     up_pulse;
  logic                     down_pulse;
  logic                     next_pulse;
  logic                     back_pulse;
  logic                     clear_pulse;
  logic [CW-1:0]            cursor;
  logic [DW-1:0]            current_digit;
  logic [NUM_DIGITS*DW-1:0] code_value;
  logic                     entry_complete;
  logic                     entry_active;
  logic                     timeout_flag;

  modport master (
    output enable_entry, up_pulse, down_pulse,
    output next_pulse, back_pulse, clear_pulse,
    input  cursor, current_digit, code_value,
    input  entry_complete, entry_active, timeout_flag
  );

  modport slave (
    input  enable_entry, up_pulse, down_pulse,
    input  next_pulse, back_pulse, clear_pulse,
    output cursor, current_digit, code_value,
    output entry_complete, entry_active, timeout_flag
  );
endinterface

// File: rtl/code_entry_selector.sv
// Multi-digit code editor with cursor, commit strobe and optional idle clear.
// Define ENTRY_TIMEOUT_EN to build the idle auto-clear counter.
module code_entry_selector #(
  parameter int NUM_DIGITS = 4,
  parameter int RADIX = 10,
  parameter int DW = 4,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input logic clk,
  input logic sys_reset,
  code_entry_selector_if.slave bus
);
  localparam int CW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] TOP = DW'(RADIX - 1);

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    DONE
  } state_t;

  state_t                   state;
  logic [NUM_DIGITS*DW-1:0] code_q;
  logic [CW-1:0]            cur_q;
  logic                     done_q;
  logic                     tmo_hit;

  logic                     any_pulse;
  logic                     fwd;
  logic                     rev;
  logic                     inc;
  logic                     dec;
  logic                     moving;
  logic [DW-1:0]            dig;
  logic [DW-1:0]            dig_up;
  logic [DW-1:0]            dig_dn;

  assign any_pulse = bus.up_pulse | bus.down_pulse |
                     bus.next_pulse | bus.back_pulse |
                     bus.clear_pulse;
  assign fwd    = bus.next_pulse & ~bus.back_pulse;
  assign rev    = bus.back_pulse & ~bus.next_pulse;
  assign moving = bus.next_pulse | bus.back_pulse;
  assign inc    = bus.up_pulse & ~bus.down_pulse;
  assign dec    = bus.down_pulse & ~bus.up_pulse;

  assign dig    = code_q[cur_q*DW +: DW];
  assign dig_up = (dig == TOP) ? '0 : dig + 1'b1;
  assign dig_dn = (dig == '0) ? TOP : dig - 1'b1;

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state  <= IDLE;
      code_q <= '0;
      cur_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.enable_entry) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: state <= EDIT;
          EDIT: begin
            if (tmo_hit || bus.clear_pulse) begin
              code_q <= '0;
              cur_q  <= '0;
            end else if (fwd) begin
              if (cur_q == LAST) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                cur_q <= cur_q + 1'b1;
              end
            end else if (rev) begin
              if (cur_q != '0) cur_q <= cur_q - 1'b1;
            end else if (!moving) begin
              // next+back cancel the move yet still mask up/down
              if (inc) code_q[cur_q*DW +: DW] <= dig_up;
              else if (dec) code_q[cur_q*DW +: DW] <= dig_dn;
            end
          end
          DONE: begin
            if (bus.clear_pulse) begin
              state  <= EDIT;
              code_q <= '0;
              cur_q  <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_q;
  logic          tmo_q;

  assign tmo_hit = (state == EDIT) && bus.enable_entry &&
                   !any_pulse && (idle_q == IDLE_MAX);

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (state != EDIT || !bus.enable_entry ||
          any_pulse || tmo_hit)
        idle_q <= '0;
      else
        idle_q <= idle_q + 1'b1;
    end
  end

  assign bus.timeout_flag = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  assign bus.cursor         = cur_q;
  assign bus.current_digit  = dig;
  assign bus.code_value     = code_q;
  assign bus.entry_complete = done_q;
  assign bus.entry_active   = (state == EDIT);
endmodule
